// File: rtl/fnn_seq_ctrl.sv
// Control sequencer for the two-layer fixed-point FNN datapath: walks hidden and
// output layers by group/chunk/beat per sample, with start/done, memory stalls and abort.
module fnn_seq_ctrl #(
    parameter int BEATS       = 4,
    parameter int HID_CHUNKS  = 8,
    parameter int HID_GROUPS  = 4,
    parameter int OUT_CHUNKS  = 4,
    parameter int OUT_GROUPS  = 2,
    parameter int NUM_SAMPLES = 750,
    localparam int CMAX = (HID_CHUNKS > OUT_CHUNKS) ? HID_CHUNKS : OUT_CHUNKS,
    localparam int GMAX = (HID_GROUPS > OUT_GROUPS) ? HID_GROUPS : OUT_GROUPS,
    localparam int BW   = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1,
    localparam int GW   = (GMAX > 1) ? $clog2(GMAX) : 1,
    localparam int SW   = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          mem_valid_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          mem_read_o,
    output logic          layer_sel_o,
    output logic          acc_en_o,
    output logic          acc_clr_o,
    output logic          grp_ld_o,
    output logic          hid_ld_o,
    output logic          out_valid_o,
    output logic [BW-1:0] beat_idx_o,
    output logic [CW-1:0] chunk_idx_o,
    output logic [GW-1:0] group_idx_o,
    output logic [SW-1:0] sample_idx_o
);

    typedef enum logic [2:0] {
        IDLE, HID_CALC, HID_LATCH, OUT_CALC, SAMPLE_NEXT, DONE
    } state_e;

    localparam logic [BW-1:0] BEAT_LAST      = BW'(BEATS - 1);
    localparam logic [CW-1:0] HID_CHUNK_LAST = CW'(HID_CHUNKS - 1);
    localparam logic [CW-1:0] OUT_CHUNK_LAST = CW'(OUT_CHUNKS - 1);
    localparam logic [GW-1:0] HID_GROUP_LAST = GW'(HID_GROUPS - 1);
    localparam logic [GW-1:0] OUT_GROUP_LAST = GW'(OUT_GROUPS - 1);
    localparam logic [SW-1:0] SAMPLE_LAST    = SW'(NUM_SAMPLES - 1);

    state_e        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [CW-1:0] chunk_q, chunk_d;
    logic [GW-1:0] group_q, group_d;
    logic [SW-1:0] sample_q, sample_d;

    logic calc, layer_out, beat_wrap, chunk_wrap, group_wrap;

    assign calc       = (state_q == HID_CALC) || (state_q == OUT_CALC);
    assign layer_out  = (state_q == OUT_CALC);
    assign beat_wrap  = (beat_q == BEAT_LAST);
    assign chunk_wrap = (chunk_q == (layer_out ? OUT_CHUNK_LAST : HID_CHUNK_LAST));
    assign group_wrap = (group_q == (layer_out ? OUT_GROUP_LAST : HID_GROUP_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            chunk_q  <= '0;
            group_q  <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            chunk_q  <= chunk_d;
            group_q  <= group_d;
            sample_q <= sample_d;
        end
    end

    always_comb begin
        // NOTE: every next-state variable defaults to its hold value first, so no path infers a latch.
        state_d  = state_q;
        beat_d   = beat_q;
        chunk_d  = chunk_q;
        group_d  = group_q;
        sample_d = sample_q;

        if (abort_i) begin
            state_d  = IDLE;
            beat_d   = '0;
            chunk_d  = '0;
            group_d  = '0;
            sample_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d  = HID_CALC;
                        beat_d   = '0;
                        chunk_d  = '0;
                        group_d  = '0;
                        sample_d = '0;
                    end
                end
                HID_CALC, OUT_CALC: begin
                    // Nested beat -> chunk -> group rollover, advancing only on valid memory words.
                    if (mem_valid_i) begin
                        if (!beat_wrap) begin
                            beat_d = beat_q + 1'b1;
                        end else begin
                            beat_d = '0;
                            if (!chunk_wrap) begin
                                chunk_d = chunk_q + 1'b1;
                            end else begin
                                chunk_d = '0;
                                if (!group_wrap) begin
                                    group_d = group_q + 1'b1;
                                end else begin
                                    group_d = '0;
                                    state_d = layer_out ? SAMPLE_NEXT : HID_LATCH;
                                end
                            end
                        end
                    end
                end
                HID_LATCH: begin
                    beat_d  = '0;
                    chunk_d = '0;
                    group_d = '0;
                    state_d = OUT_CALC;
                end
                SAMPLE_NEXT: begin
                    beat_d  = '0;
                    chunk_d = '0;
                    group_d = '0;
                    if (sample_q == SAMPLE_LAST) begin
                        state_d = DONE;
                    end else begin
                        sample_d = sample_q + 1'b1;
                        state_d  = HID_CALC;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Moore decode; only acc_en and grp_ld see mem_valid combinationally.
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign mem_read_o   = calc;
    assign layer_sel_o  = layer_out;
    assign acc_en_o     = calc & mem_valid_i;
    assign acc_clr_o    = (state_q == HID_LATCH) || (state_q == SAMPLE_NEXT);
    assign grp_ld_o     = calc & mem_valid_i & beat_wrap & chunk_wrap;
    assign hid_ld_o     = (state_q == HID_LATCH);
    assign out_valid_o  = (state_q == SAMPLE_NEXT);
    assign beat_idx_o   = beat_q;
    assign chunk_idx_o  = chunk_q;
    assign group_idx_o  = group_q;
    assign sample_idx_o = sample_q;

endmodule

// File: tb/tb_fnn_seq_ctrl.sv
// Self-checking bench for fnn_seq_ctrl: a directed vector table, hand-written corner
// sequences and a randomized run, all compared against a flat-position reference model.
module tb_fnn_seq_ctrl;

    localparam int B  = 4;
    localparam int HC = 8;
    localparam int HG = 4;
    localparam int OC = 4;
    localparam int OG = 2;
    localparam int NS = 3;
    localparam int HID_LEN    = HG * HC * B;
    localparam int OUT_LEN    = OG * OC * B;
    localparam int SAMPLE_LEN = HID_LEN + 1 + OUT_LEN + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0, abort_i = 1'b0, mem_valid_i = 1'b0;
    logic       busy_o, done_o, mem_read_o, layer_sel_o, acc_en_o, acc_clr_o;
    logic       grp_ld_o, hid_ld_o, out_valid_o;
    logic [1:0] beat_idx_o;
    logic [2:0] chunk_idx_o;
    logic [1:0] group_idx_o;
    logic [1:0] sample_idx_o;

    int n_vec = 0;
    int n_err = 0;

    fnn_seq_ctrl #(
        .BEATS(B), .HID_CHUNKS(HC), .HID_GROUPS(HG),
        .OUT_CHUNKS(OC), .OUT_GROUPS(OG), .NUM_SAMPLES(NS)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .mem_valid_i(mem_valid_i), .busy_o(busy_o), .done_o(done_o),
        .mem_read_o(mem_read_o), .layer_sel_o(layer_sel_o), .acc_en_o(acc_en_o),
        .acc_clr_o(acc_clr_o), .grp_ld_o(grp_ld_o), .hid_ld_o(hid_ld_o),
        .out_valid_o(out_valid_o), .beat_idx_o(beat_idx_o), .chunk_idx_o(chunk_idx_o),
        .group_idx_o(group_idx_o), .sample_idx_o(sample_idx_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sample is a flat sequence of SAMPLE_LEN positions; indices are
    // derived arithmetically from the position, not tracked as nested counters.
    bit m_active, m_done;
    int m_pos, m_s;

    task automatic model_reset();
        m_active = 0; m_done = 0; m_pos = 0; m_s = 0;
    endtask

    function automatic bit model_calc();
        return m_active && (m_pos < HID_LEN || (m_pos > HID_LEN && m_pos < HID_LEN + 1 + OUT_LEN));
    endfunction

    task automatic model_step(input bit st, input bit ab, input bit mv);
        if (ab) begin
            model_reset();
            return;
        end
        if (m_done) begin
            m_done = 0;
            return;
        end
        if (!m_active) begin
            if (st) begin m_active = 1; m_pos = 0; m_s = 0; end
            return;
        end
        if (model_calc() && !mv) return;
        if (m_pos == SAMPLE_LEN - 1) begin
            m_pos = 0;
            if (m_s == NS - 1) begin m_active = 0; m_done = 1; end
            else m_s++;
        end else begin
            m_pos++;
        end
    endtask

    task automatic compare_outputs(input bit mv);
        bit calc, outl;
        int t, ch;
        calc = 0; outl = 0; t = 0; ch = HC;
        if (m_active && m_pos < HID_LEN) begin
            calc = 1; t = m_pos;
        end else if (m_active && m_pos > HID_LEN && m_pos < HID_LEN + 1 + OUT_LEN) begin
            calc = 1; outl = 1; t = m_pos - HID_LEN - 1; ch = OC;
        end
        check("busy",      int'(busy_o),       int'(m_active || m_done));
        check("done",      int'(done_o),       int'(m_done));
        check("mem_read",  int'(mem_read_o),   int'(calc));
        check("layer_sel", int'(layer_sel_o),  int'(outl));
        check("acc_en",    int'(acc_en_o),     int'(calc && mv));
        check("acc_clr",   int'(acc_clr_o),    int'(m_active && (m_pos == HID_LEN || m_pos == SAMPLE_LEN - 1)));
        check("grp_ld",    int'(grp_ld_o),     int'(calc && mv && ((t + 1) % (B * ch) == 0)));
        check("hid_ld",    int'(hid_ld_o),     int'(m_active && m_pos == HID_LEN));
        check("out_valid", int'(out_valid_o),  int'(m_active && m_pos == SAMPLE_LEN - 1));
        check("beat_idx",  int'(beat_idx_o),   calc ? t % B : 0);
        check("chunk_idx", int'(chunk_idx_o),  calc ? (t / B) % ch : 0);
        check("group_idx", int'(group_idx_o),  calc ? t / (B * ch) : 0);
        check("sample_idx", int'(sample_idx_o), m_s);
    endtask

    // Outputs seen in the cycle most recently passed through run_cycle.
    logic obs_busy, obs_done, obs_grp_ld, obs_hid_ld, obs_out_valid, obs_acc_en, obs_layer;
    int   obs_beat, obs_chunk, obs_group, obs_sample;

    // Called at posedge+1: drive, compare mid-cycle, then clock both DUT and model.
    task automatic run_cycle(input bit st, input bit ab, input bit mv);
        start_i = st; abort_i = ab; mem_valid_i = mv;
        #1;
        compare_outputs(mv);
        obs_busy = busy_o; obs_done = done_o; obs_grp_ld = grp_ld_o; obs_hid_ld = hid_ld_o;
        obs_out_valid = out_valid_o; obs_acc_en = acc_en_o; obs_layer = layer_sel_o;
        obs_beat = int'(beat_idx_o); obs_chunk = int'(chunk_idx_o);
        obs_group = int'(group_idx_o); obs_sample = int'(sample_idx_o);
        @(posedge clk);
        model_step(st, ab, mv);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; mem_valid_i = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_to_done(input int max_cycles, output int done_c);
        done_c = -1;
        for (int c = 1; c <= max_cycles; c++) begin
            run_cycle(1'b0, 1'b0, 1'b1);
            if (obs_done) begin done_c = c; return; end
        end
    endtask

    typedef struct {
        bit st, ab, mv;
        bit e_busy;
        int e_beat, e_chunk;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int done_c, n_hid, n_ov, n_grp, last_ov, ov_k;
        int ov_samples[3];

        tbl[0]  = '{0, 0, 1, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 1, 0, 0};
        tbl[2]  = '{0, 0, 1, 1, 1, 0};
        tbl[3]  = '{0, 0, 0, 1, 1, 0};
        tbl[4]  = '{0, 0, 1, 1, 2, 0};
        tbl[5]  = '{0, 0, 1, 1, 3, 0};
        tbl[6]  = '{0, 0, 1, 1, 0, 1};
        tbl[7]  = '{1, 0, 1, 1, 1, 1};
        tbl[8]  = '{0, 1, 1, 0, 0, 0};
        tbl[9]  = '{1, 1, 0, 0, 0, 0};
        tbl[10] = '{1, 0, 0, 1, 0, 0};
        tbl[11] = '{0, 0, 0, 1, 0, 0};

        // Reset state.
        do_reset();
        #1;
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_mem_read", int'(mem_read_o), 0);
        check("rst_sample", int'(sample_idx_o), 0);

        // Directed vector table; each row is applied at an edge and the Moore outputs checked.
        for (int i = 0; i < 12; i++) begin
            start_i = tbl[i].st; abort_i = tbl[i].ab; mem_valid_i = tbl[i].mv;
            @(posedge clk); #1;
            check($sformatf("tbl%0d_busy", i), int'(busy_o), int'(tbl[i].e_busy));
            check($sformatf("tbl%0d_beat", i), int'(beat_idx_o), tbl[i].e_beat);
            check($sformatf("tbl%0d_chunk", i), int'(chunk_idx_o), tbl[i].e_chunk);
        end

        // Full run without stalls: latency, pulse counts, sample stepping and spacing.
        do_reset();
        run_cycle(1'b1, 1'b0, 1'b1);
        n_hid = 0; n_ov = 0; n_grp = 0; last_ov = 0; ov_k = 0; done_c = -1;
        for (int c = 1; c <= 600; c++) begin
            run_cycle(1'b0, 1'b0, 1'b1);
            if (c == 1) check("busy_cycle1", int'(obs_busy), 1);
            if (obs_hid_ld) n_hid++;
            if (obs_grp_ld) n_grp++;
            if (obs_out_valid) begin
                n_ov++;
                if (ov_k < 3) ov_samples[ov_k] = obs_sample;
                if (ov_k > 0) check("out_valid_spacing", c - last_ov, SAMPLE_LEN);
                ov_k++;
                last_ov = c;
            end
            if (obs_done) begin done_c = c; break; end
        end
        check("run_done_latency", done_c, 487);
        check("run_hid_ld_count", n_hid, 3);
        check("run_out_valid_count", n_ov, 3);
        check("run_grp_ld_count", n_grp, 18);
        for (int k = 0; k < 3; k++) check($sformatf("run_ov_sample%0d", k), ov_samples[k], k);
        run_cycle(1'b0, 1'b0, 1'b1);
        check("run_idle_after_done", int'(obs_busy), 0);
        check("run_sample_held", obs_sample, NS - 1);

        // Five-cycle stall at beat 2, chunk 3, group 1 of the hidden layer.
        do_reset();
        run_cycle(1'b1, 1'b0, 1'b1);
        done_c = -1;
        for (int c = 1; c <= 700; c++) begin
            bit mv;
            mv = !(c >= 47 && c <= 51);
            run_cycle(1'b0, 1'b0, mv);
            if (!mv) begin
                check("stall_beat", obs_beat, 2);
                check("stall_chunk", obs_chunk, 3);
                check("stall_group", obs_group, 1);
                check("stall_acc_en", int'(obs_acc_en), 0);
            end
            if (obs_done) begin done_c = c; break; end
        end
        check("stall_done_latency", done_c, 492);

        // Abort at chunk 2 of the output layer in sample 1, then a clean rerun.
        do_reset();
        run_cycle(1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 301; c++) begin
            run_cycle(1'b0, c == 300, 1'b1);
            if (c == 300) begin
                check("abort_at_chunk", obs_chunk, 2);
                check("abort_at_layer", int'(obs_layer), 1);
                check("abort_at_sample", obs_sample, 1);
            end
            if (c == 301) begin
                check("abort_busy", int'(obs_busy), 0);
                check("abort_done", int'(obs_done), 0);
                check("abort_idx", obs_beat + obs_chunk + obs_group + obs_sample, 0);
            end
        end
        run_cycle(1'b1, 1'b0, 1'b1);
        run_to_done(600, done_c);
        check("abort_rerun_latency", done_c, 487);

        // start while busy and in the DONE cycle is ignored.
        do_reset();
        run_cycle(1'b1, 1'b0, 1'b1);
        done_c = -1;
        for (int c = 1; c <= 600; c++) begin
            run_cycle((c == 10) || (c == 487), 1'b0, 1'b1);
            if (obs_done) begin done_c = c; break; end
        end
        check("ign_start_latency", done_c, 487);
        for (int k = 0; k < 5; k++) begin
            run_cycle(1'b0, 1'b0, 1'b1);
            check("ign_start_idle", int'(obs_busy), 0);
        end

        // Asynchronous reset mid hidden layer: outputs clear before the next edge.
        do_reset();
        run_cycle(1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 50; c++) run_cycle(1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", int'(busy_o), 0);
        check("arst_mem_read", int'(mem_read_o), 0);
        check("arst_beat", int'(beat_idx_o), 0);
        check("arst_chunk", int'(chunk_idx_o), 0);
        check("arst_group", int'(group_idx_o), 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            run_cycle(1'b0, 1'b0, 1'b1);
            check("arst_stays_idle", int'(obs_busy), 0);
        end
        run_cycle(1'b1, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b0, 1'b1);
        check("arst_restart", int'(obs_busy), 1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            run_cycle(($urandom % 16) == 0, ($urandom % 700) == 0, ($urandom % 4) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
